// File: rtl/rcosc_rst_sequencer_if.sv
// Control and status bundle for the RC-oscillator reset sequencer.
// The sequencer drives resets/status (master); the consumer side supplies
// lock and restart (slave).
interface rcosc_rst_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  PLL_LOCK;
  logic                  REQ_RESTART;
  logic [NUM_STAGES-1:0] STAGE_RESET_N;
  logic                  SEQ_DONE;
  logic                  FAULT;
  logic                  LOCK_LOST;
  logic [2:0]            STATE;

  modport master (
    input  PLL_LOCK,
    input  REQ_RESTART,
    output STAGE_RESET_N,
    output SEQ_DONE,
    output FAULT,
    output LOCK_LOST,
    output STATE
  );

  modport slave (
    output PLL_LOCK,
    output REQ_RESTART,
    input  STAGE_RESET_N,
    input  SEQ_DONE,
    input  FAULT,
    input  LOCK_LOST,
    input  STATE
  );
endinterface

// File: rtl/rcosc_rst_sequencer.sv
// Reset/start-up sequencer: waits for the RC oscillator to settle,
// qualifies the downstream lock, releases per-domain active-low resets in
// ascending order with a fixed gap, then supervises lock while running.
module rcosc_rst_sequencer #(
  parameter int unsigned NUM_STAGES    = 4,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned LOCK_FILTER   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STAGE_GAP     = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  RCOSC_160MHZ_CLK_DIV,
  input  logic                  RESET,
  rcosc_rst_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      FILTER_HIT  = CNT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0]      TIMEOUT_HIT = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0]      GAP_RELOAD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;       // settle / timeout / gap counter
  logic [CNT_W-1:0]      flt_q, flt_d;       // consecutive-lock filter
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  seq_done_q, seq_done_d;
  logic                  fault_q, fault_d;
  logic                  lock_lost_q, lock_lost_d;
  logic                  restart;
  logic                  loss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, counter and output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flt_d       = flt_q;
    rst_n_d     = rst_n_q;
    lock_lost_d = lock_lost_q;

    restart = bus.REQ_RESTART && (state_q != ST_IDLE);
    loss    = !bus.PLL_LOCK && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

    // Restart and lock loss share one re-sequence path; the sticky flag is
    // recorded independently so a coincident restart cannot mask it.
    if (loss) lock_lost_d = 1'b1;

    if (restart || loss) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
      flt_d   = '0;
      rst_n_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          flt_d   = '0;
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            flt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_WAIT_LOCK: begin
          flt_d = bus.PLL_LOCK ? sat_inc(flt_q) : '0;
          cnt_d = sat_inc(cnt_q);
          if (flt_d == FILTER_HIT) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            flt_d   = '0;
            rst_n_d = '0;
          end else if (cnt_d == TIMEOUT_HIT) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            flt_d   = '0;
          end
        end
        ST_RELEASE: begin
          // Gap counter counts down; at zero either release the next stage
          // (shift in a one) or, with every stage out, move to RUN.
          if (cnt_q == '0) begin
            if (rst_n_q[NUM_STAGES-1]) begin
              state_d = ST_RUN;
            end else begin
              rst_n_d = (rst_n_q << 1) | FIRST_STAGE;
              cnt_d   = GAP_RELOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          rst_n_d = '1;
        end
        ST_FAULT: begin
          rst_n_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          flt_d   = '0;
          rst_n_d = '0;
        end
      endcase
    end

    seq_done_d = (state_d == ST_RUN);
    fault_d    = (state_d == ST_FAULT);
  end

  // State, counters and registered outputs
  always_ff @(posedge RCOSC_160MHZ_CLK_DIV) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      flt_q       <= '0;
      rst_n_q     <= '0;
      seq_done_q  <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flt_q       <= flt_d;
      rst_n_q     <= rst_n_d;
      seq_done_q  <= seq_done_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.STAGE_RESET_N = rst_n_q;
  assign bus.SEQ_DONE      = seq_done_q;
  assign bus.FAULT         = fault_q;
  assign bus.LOCK_LOST     = lock_lost_q;
  assign bus.STATE         = state_q;

endmodule

// File: tb/tb_rcosc_rst_sequencer.sv
// Directed bench for rcosc_rst_sequencer with small parameters:
// NUM_STAGES=4, SETTLE_CYCLES=8, LOCK_FILTER=4, LOCK_TIMEOUT=32, STAGE_GAP=4.
module tb_rcosc_rst_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_WAIT = 3'd2,
                         S_REL  = 3'd3, S_RUN    = 3'd4, S_FAULT = 3'd5;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rcosc_rst_sequencer_if #(.NUM_STAGES(4)) bus ();

  rcosc_rst_sequencer #(
    .NUM_STAGES   (4),
    .SETTLE_CYCLES(8),
    .LOCK_FILTER  (4),
    .LOCK_TIMEOUT (32),
    .STAGE_GAP    (4),
    .CNT_W        (16)
  ) dut (
    .RCOSC_160MHZ_CLK_DIV(clk),
    .RESET               (rst),
    .bus                 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] rn, input logic done,
                            input logic flt, input logic lost, input logic [2:0] st);
    chk({tag, ".stage_reset_n"}, 32'(bus.STAGE_RESET_N), 32'(rn));
    chk({tag, ".seq_done"},      32'(bus.SEQ_DONE),      32'(done));
    chk({tag, ".fault"},         32'(bus.FAULT),         32'(flt));
    chk({tag, ".lock_lost"},     32'(bus.LOCK_LOST),     32'(lost));
    chk({tag, ".state"},         32'(bus.STATE),         32'(st));
  endtask

  // Eight SETTLE cycles starting at the first SETTLE cycle; lock is a don't-care here.
  task automatic settle_phase(input logic lost, input logic lock);
    for (int i = 0; i < 8; i++) begin
      bus.PLL_LOCK = lock;
      expect_out("settle", 4'h0, 1'b0, 1'b0, lost, S_SETTLE);
      tick();
    end
  endtask

  // Drive lock pattern (bit 0 first) for n WAIT_LOCK cycles.
  task automatic wait_lock(input logic [63:0] bits, input int n, input logic lost);
    for (int i = 0; i < n; i++) begin
      bus.PLL_LOCK = bits[i];
      expect_out("wait_lock", 4'h0, 1'b0, 1'b0, lost, S_WAIT);
      tick();
    end
  endtask

  // Expected resets t cycles after RELEASE first reads (gap 4, bit k at 4k+1).
  function automatic logic [3:0] rn_exp(input int t);
    if (t == 0)  return 4'b0000;
    if (t <= 4)  return 4'b0001;
    if (t <= 8)  return 4'b0011;
    if (t <= 12) return 4'b0111;
    return 4'b1111;
  endfunction

  task automatic release_to(input int n, input logic lost);
    for (int t = 0; t < n; t++) begin
      bus.PLL_LOCK = 1'b1;
      expect_out("release", rn_exp(t), 1'b0, 1'b0, lost, S_REL);
      tick();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.PLL_LOCK = 1'b1;
    bus.REQ_RESTART = 1'b0;
    tick();
    tick();
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE);

    // Nominal bring-up: IDLE one cycle, SETTLE 8, WAIT_LOCK 4, release, RUN.
    rst = 1'b0;
    expect_out("idle", 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE);
    tick();
    settle_phase(1'b0, 1'b1);
    wait_lock(64'hF, 4, 1'b0);
    release_to(17, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_out("run", 4'hF, 1'b1, 1'b0, 1'b0, S_RUN);
      tick();
    end

    // Restart from RUN, then glitchy lock 1,1,1,0,1,1,1,1.
    bus.REQ_RESTART = 1'b1;
    tick();
    bus.REQ_RESTART = 1'b0;
    expect_out("restart_run", 4'h0, 1'b0, 1'b0, 1'b0, S_SETTLE);
    settle_phase(1'b0, 1'b0);
    wait_lock(64'hF7, 8, 1'b0);

    // Lock loss plus restart mid-RELEASE after 0011.
    release_to(5, 1'b0);
    expect_out("mid_release", 4'b0011, 1'b0, 1'b0, 1'b0, S_REL);
    bus.PLL_LOCK = 1'b0;
    bus.REQ_RESTART = 1'b1;
    tick();
    bus.PLL_LOCK = 1'b1;
    bus.REQ_RESTART = 1'b0;
    expect_out("loss_restart", 4'h0, 1'b0, 1'b0, 1'b1, S_SETTLE);
    settle_phase(1'b1, 1'b1);
    wait_lock(64'hF, 4, 1'b1);
    release_to(17, 1'b1);
    expect_out("run2", 4'hF, 1'b1, 1'b0, 1'b1, S_RUN);

    // Lock loss in RUN for one cycle, full re-sequence keeps LOCK_LOST.
    bus.PLL_LOCK = 1'b0;
    tick();
    bus.PLL_LOCK = 1'b1;
    expect_out("loss_run", 4'h0, 1'b0, 1'b0, 1'b1, S_SETTLE);
    settle_phase(1'b1, 1'b1);
    wait_lock(64'hF, 4, 1'b1);
    release_to(17, 1'b1);
    expect_out("run3", 4'hF, 1'b1, 1'b0, 1'b1, S_RUN);

    // Timeout: no lock for 32 WAIT_LOCK cycles -> FAULT, held despite lock.
    bus.PLL_LOCK = 1'b0;
    bus.REQ_RESTART = 1'b1;
    tick();
    bus.REQ_RESTART = 1'b0;
    settle_phase(1'b1, 1'b0);
    wait_lock(64'h0, 32, 1'b1);
    expect_out("fault", 4'h0, 1'b0, 1'b1, 1'b1, S_FAULT);
    bus.PLL_LOCK = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("fault_hold", 4'h0, 1'b0, 1'b1, 1'b1, S_FAULT);
    end
    bus.REQ_RESTART = 1'b1;
    tick();
    bus.REQ_RESTART = 1'b0;
    expect_out("fault_exit", 4'h0, 1'b0, 1'b0, 1'b1, S_SETTLE);

    // Filter completes on the same cycle the timeout expires: RELEASE wins.
    settle_phase(1'b1, 1'b0);
    wait_lock(64'hF000_0000, 32, 1'b1);
    release_to(9, 1'b1);
    expect_out("pre_reset", 4'b0111, 1'b0, 1'b0, 1'b1, S_REL);

    // RESET mid-release: everything back to reset values.
    rst = 1'b1;
    tick();
    expect_out("reset_mid", 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE);
    rst = 1'b0;
    tick();
    expect_out("reset_exit", 4'h0, 1'b0, 1'b0, 1'b0, S_SETTLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
